// File: rtl/stream_protocol_checker.sv
// Passive valid/ready stream monitor: flags stall-time protocol violations (payload change,
// valid drop, stall timeout) and keeps handshake/stall statistics.
module stream_protocol_checker #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  valid_i,
  input  logic                  ready_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  err_data_o,
  output logic                  err_valid_o,
  output logic                  err_timeout_o,
  output logic [1:0]            first_err_o,
  output logic                  irq_o,
  output logic [CNT_WIDTH-1:0]  hs_count_o,
  output logic [CNT_WIDTH-1:0]  stall_count_o,
  output logic [CNT_WIDTH-1:0]  max_stall_o
);

  localparam int unsigned TimeoutM1 = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CNT_WIDTH-1:0] CntMax = '1;
  localparam logic [CNT_WIDTH-1:0] CntOne = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic                  stalled_q, stalled_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  skip_q, skip_d;
  logic                  timed_out_q, timed_out_d;
  logic                  err_data_q, err_data_d;
  logic                  err_valid_q, err_valid_d;
  logic                  err_timeout_q, err_timeout_d;
  logic [1:0]            first_err_q, first_err_d;
  logic                  irq_q, irq_d;
  logic [CNT_WIDTH-1:0]  hs_count_q, hs_count_d;
  logic [CNT_WIDTH-1:0]  stall_count_q, stall_count_d;
  logic [CNT_WIDTH-1:0]  max_stall_q, max_stall_d;

  logic stall, handshake;
  logic viol_data, viol_valid, viol_timeout;

  always_comb begin
    stall     = valid_i & ~ready_i;
    handshake = valid_i & ready_i;
    // skip_q masks all checks for the first cycle after reset or clear.
    viol_data    = ~skip_q & stalled_q & valid_i & (data_i != data_q);
    viol_valid   = ~skip_q & stalled_q & ~valid_i;
    viol_timeout = (TIMEOUT_CYCLES != 0) & ~skip_q & stall & ~timed_out_q &
                   (32'(stall_count_q) == TimeoutM1);
  end

  always_comb begin
    stalled_d     = stall;
    data_d        = data_i;
    skip_d        = 1'b0;
    timed_out_d   = stall & (timed_out_q | viol_timeout);
    err_data_d    = err_data_q | viol_data;
    err_valid_d   = err_valid_q | viol_valid;
    err_timeout_d = err_timeout_q | viol_timeout;
    first_err_d   = first_err_q;
    irq_d         = 1'b0;
    hs_count_d    = handshake ? hs_count_q + CntOne : hs_count_q;
    stall_count_d = '0;
    max_stall_d   = max_stall_q;

    if (stall) begin
      stall_count_d = (stall_count_q == CntMax) ? stall_count_q : stall_count_q + CntOne;
    end
    if (stall_count_d > max_stall_q) begin
      max_stall_d = stall_count_d;
    end

    if (first_err_q == 2'd0) begin
      if (viol_data) begin
        first_err_d = 2'd1;
      end else if (viol_valid) begin
        first_err_d = 2'd2;
      end else if (viol_timeout) begin
        first_err_d = 2'd3;
      end
      irq_d = (first_err_d != 2'd0);
    end

    if (clear_i) begin
      stalled_d     = 1'b0;
      skip_d        = 1'b1;
      timed_out_d   = 1'b0;
      err_data_d    = 1'b0;
      err_valid_d   = 1'b0;
      err_timeout_d = 1'b0;
      first_err_d   = 2'd0;
      irq_d         = 1'b0;
      hs_count_d    = '0;
      stall_count_d = '0;
      max_stall_d   = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stalled_q     <= 1'b0;
      data_q        <= '0;
      skip_q        <= 1'b1;
      timed_out_q   <= 1'b0;
      err_data_q    <= 1'b0;
      err_valid_q   <= 1'b0;
      err_timeout_q <= 1'b0;
      first_err_q   <= 2'd0;
      irq_q         <= 1'b0;
      hs_count_q    <= '0;
      stall_count_q <= '0;
      max_stall_q   <= '0;
    end else begin
      stalled_q     <= stalled_d;
      data_q        <= data_d;
      skip_q        <= skip_d;
      timed_out_q   <= timed_out_d;
      err_data_q    <= err_data_d;
      err_valid_q   <= err_valid_d;
      err_timeout_q <= err_timeout_d;
      first_err_q   <= first_err_d;
      irq_q         <= irq_d;
      hs_count_q    <= hs_count_d;
      stall_count_q <= stall_count_d;
      max_stall_q   <= max_stall_d;
    end
  end

  assign err_data_o    = err_data_q;
  assign err_valid_o   = err_valid_q;
  assign err_timeout_o = err_timeout_q;
  assign first_err_o   = first_err_q;
  assign irq_o         = irq_q;
  assign hs_count_o    = hs_count_q;
  assign stall_count_o = stall_count_q;
  assign max_stall_o   = max_stall_q;

endmodule

// File: doc/stream_protocol_checker.md
STREAM_PROTOCOL_CHECKER -- requirements
Module: stream_protocol_checker

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of the monitored payload.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 256: number of consecutive stall cycles that raises a timeout; 0 disables the timeout.
REQ-003 SHALL have parameter CNT_WIDTH, default 16: width of all statistic counters.
REQ-004 SHALL have one clock and one reset: the reset is asynchronous and active-high.
REQ-005 clk_i  input  1  clock; all state updates on the rising edge.
REQ-006 rst_i  input  1  asynchronous, active-high reset.
REQ-007 clear_i  input  1  synchronous clear of flags, counters and history.
REQ-008 valid_i  input  1  monitored stream valid (passive tap).
REQ-009 ready_i  input  1  monitored stream ready (passive tap).
REQ-010 data_i  input  DATA_WIDTH  monitored stream payload.
REQ-011 err_data_o  output  1  sticky flag: payload changed while stalled.
REQ-012 err_valid_o  output  1  sticky flag: valid dropped while stalled.
REQ-013 err_timeout_o  output  1  sticky flag: stall reached TIMEOUT_CYCLES.
REQ-014 first_err_o  output  2  code of the first violation: 0 none, 1 data, 2 valid, 3 timeout.
REQ-015 irq_o  output  1  one-cycle pulse when the first violation is recorded.
REQ-016 hs_count_o  output  CNT_WIDTH  count of completed handshakes.
REQ-017 stall_count_o  output  CNT_WIDTH  length of the current consecutive stall.
REQ-018 max_stall_o  output  CNT_WIDTH  longest consecutive stall observed.

Function
REQ-019 SHALL be purely passive: no output feeds back into valid_i, ready_i or data_i.
REQ-020 SHALL define a stall cycle as valid_i=1 with ready_i=0, and a handshake as valid_i=1 with ready_i=1.
REQ-021 SHALL register a history bit, stalled_q, and the payload, data_q, on every cycle; stalled_q is set on a stall cycle and cleared otherwise.
REQ-022 SHALL detect a valid violation in any cycle where stalled_q=1 and valid_i=0.
REQ-023 SHALL detect a data violation in any cycle where stalled_q=1, valid_i=1 and data_i differs from data_q.
REQ-024 SHALL increment stall_count_o on each stall cycle, saturating at 2^CNT_WIDTH-1.
REQ-025 SHALL reset stall_count_o to 0 on a handshake or when valid_i=0.
REQ-026 SHALL detect a timeout when TIMEOUT_CYCLES>0 and a stall cycle occurs with stall_count_o equal to TIMEOUT_CYCLES-1, i.e. on the TIMEOUT_CYCLES-th consecutive stall.
REQ-027 SHALL detect a timeout at most once per stall episode.
REQ-028 SHALL register all error flags, so a violation detected in cycle t is visible from cycle t+1.
REQ-029 SHALL keep each error flag set until clear_i or reset.
REQ-030 SHALL load first_err_o only while it is 0; for simultaneous violations it SHALL use priority data > valid > timeout.
REQ-031 SHALL assert irq_o for exactly the one cycle in which first_err_o changes from 0 to nonzero.
REQ-032 SHALL increment hs_count_o by 1 per handshake, wrapping modulo 2^CNT_WIDTH.
REQ-033 SHALL update max_stall_o to the new stall_count_o whenever that value exceeds max_stall_o, so it tracks the longest stall within the same cycle's update.
REQ-034 SHALL give clear_i priority over every same-cycle update: all flags, counters, first_err_o and stalled_q go to 0, and no violation is checked in the cycle after clear_i.
REQ-035 SHALL, with TIMEOUT_CYCLES=1, detect a timeout on the first stall cycle.

Reset
REQ-036 SHALL, while rst_i=1, asynchronously drive every output to 0 and clear stalled_q, data_q and all counters.
REQ-037 SHALL perform no violation check on the first cycle after rst_i deasserts, including when reset is applied mid-stall.

Verification
REQ-038 Scenario: stall with data=0xA5 for 3 cycles, data changes to 0x5A on the 4th cycle -> err_data_o=1 and first_err_o=1 from the 5th cycle; irq_o high for that one cycle only.
REQ-039 Scenario: stall 2 cycles, then valid_i=0 -> err_valid_o=1 and first_err_o=2 next cycle; err_data_o stays 0.
REQ-040 Scenario: TIMEOUT_CYCLES=4, stall held 10 cycles -> err_timeout_o rises after the 4th stall cycle; irq_o pulses once; stall_count_o=10; max_stall_o=10.
REQ-041 Scenario: CNT_WIDTH=4, 17 back-to-back handshakes -> hs_count_o=1; no error flags set.
REQ-042 Scenario: err_data_o set, then clear_i pulsed in the same cycle as a valid drop -> all flags, first_err_o and counters are 0 afterwards; a later violation pulses irq_o again.
REQ-043 Scenario: rst_i asserted asynchronously mid-stall, then released while the stall continues with new data -> outputs 0 immediately; no error on the first post-reset cycle.
